// File: rtl/regfile_mp.sv
// Multi-port register file: NWR prioritised write ports and NRD registered read
// ports with write-first bypass. A clear sequencer zeroes the array after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs    [DEPTH];
  logic [DATA_W-1:0]   rd_next [NRD];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == ADDR_W'(DEPTH - 1)) begin
      state_nxt = RUN;
    end
  end

  // ready is taken straight from the state register, so it has no input path
  assign ready = (state == RUN);

  // Later loop iterations override earlier ones, giving the highest port priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && !(ZERO_REG != 0 && waddr[k*ADDR_W +: ADDR_W] == '0)) begin
            regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_next[j] = regs[raddr[j*ADDR_W +: ADDR_W]];
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]) begin
          rd_next[j] = wdata[k*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG != 0 && raddr[j*ADDR_W +: ADDR_W] == '0) begin
        rd_next[j] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      rdata <= '0;
    end else begin
      for (int j = 0; j < NRD; j++) begin
        if (re[j]) begin
          rdata[j*DATA_W +: DATA_W] <= rd_next[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with a hardwired zero register and
// one without, driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [1:0]  re;
  logic [9:0]  waddr;
  logic [9:0]  raddr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic [63:0] rdata_z;
  logic        ready;
  logic        ready_z;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] z0;
    logic [31:0] z1;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .ready(ready)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_z), .ready(ready_z)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the rising edge
  task automatic applyStimulus(input logic [1:0] w, input logic [4:0] wa0,
                               input logic [31:0] wd0, input logic [4:0] wa1,
                               input logic [31:0] wd1, input logic [1:0] r,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    we    = w;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    re    = r;
    raddr = {ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  task automatic runClear(input string tag, input bit inject_write);
    for (int e = 1; e <= 32; e++) begin
      if (inject_write && e == 25)
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd20, 32'h00001234, 2'b00, 5'd0, 5'd0);
      else
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
      checkOutput($sformatf("%s ready edge %0d", tag, e), {31'b0, ready}, {31'b0, e == 32});
      checkOutput($sformatf("%s ready_z edge %0d", tag, e), {31'b0, ready_z}, {31'b0, e == 32});
    end
  endtask

  task automatic readAllZero(input string tag);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(31 - i));
      checkOutput($sformatf("%s rd0 r%0d", tag, i), rdata[31:0], 32'h0);
      checkOutput($sformatf("%s rd1 r%0d", tag, 31 - i), rdata[63:32], 32'h0);
      checkOutput($sformatf("%s z rd0 r%0d", tag, i), rdata_z[31:0], 32'h0);
    end
  endtask

  initial begin
    //         we     wa0  wd0           wa1   wd1           re     ra0   ra1   e0            e1            z0            z1
    vecs[0]  = '{2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0,        2'b11, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b10, 5'd0, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{2'b11, 5'd3, 32'h11111111, 5'd3, 32'h22222222, 2'b01, 5'd3, 5'd0, 32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
    vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd3, 5'd7, 32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
    vecs[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        2'b11, 5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd0, 5'd3, 32'h0,        32'h22222222, 32'hFFFFFFFF, 32'h22222222};
    vecs[6]  = '{2'b10, 5'd0, 32'h0,        5'd5, 32'h00000055, 2'b00, 5'd5, 5'd5, 32'h0,        32'h22222222, 32'hFFFFFFFF, 32'h22222222};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b01, 5'd5, 5'd0, 32'h00000055, 32'h22222222, 32'h00000055, 32'h22222222};
    vecs[8]  = '{2'b01, 5'd5, 32'h00000066, 5'd0, 32'h0,        2'b00, 5'd5, 5'd5, 32'h00000055, 32'h22222222, 32'h00000055, 32'h22222222};
    vecs[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 5'd5, 5'd5, 32'h00000055, 32'h22222222, 32'h00000055, 32'h22222222};
    vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b01, 5'd5, 5'd0, 32'h00000066, 32'h22222222, 32'h00000066, 32'h22222222};
    vecs[11] = '{2'b11, 5'd9, 32'h0000000A, 5'd10, 32'h0000000B, 2'b11, 5'd9, 5'd10, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h0000000B};
    vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd9, 5'd10, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h0000000B};
    vecs[13] = '{2'b11, 5'd7, 32'h00000088, 5'd0, 32'h00000077, 2'b11, 5'd0, 5'd7, 32'h0,        32'h00000088, 32'h00000077, 32'h00000088};

    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0);
      checkOutput("reset ready", {31'b0, ready}, 32'h0);
      checkOutput("reset rdata0", rdata[31:0], 32'h0);
      checkOutput("reset rdata1", rdata[63:32], 32'h0);
    end
    rst = 1'b0;

    runClear("clear", 1'b1);
    readAllZero("post-clear");

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1, vecs[v].wd1,
                    vecs[v].re, vecs[v].ra0, vecs[v].ra1);
      checkOutput($sformatf("vec%0d rd0", v), rdata[31:0], vecs[v].e0);
      checkOutput($sformatf("vec%0d rd1", v), rdata[63:32], vecs[v].e1);
      checkOutput($sformatf("vec%0d z rd0", v), rdata_z[31:0], vecs[v].z0);
      checkOutput($sformatf("vec%0d z rd1", v), rdata_z[63:32], vecs[v].z1);
    end

    for (int i = 1; i < 32; i++) begin
      applyStimulus(2'b01, 5'(i), 32'(i) * 32'h01010101, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd31);
    checkOutput("fill rd0 r1", rdata[31:0], 32'h01010101);
    checkOutput("fill rd1 r31", rdata[63:32], 32'h1F1F1F1F);
    checkOutput("fill z rd0 r1", rdata_z[31:0], 32'h01010101);

    rst = 1'b1;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd31);
    checkOutput("midreset ready", {31'b0, ready}, 32'h0);
    checkOutput("midreset ready_z", {31'b0, ready_z}, 32'h0);
    checkOutput("midreset rdata0", rdata[31:0], 32'h0);
    checkOutput("midreset rdata1", rdata[63:32], 32'h0);
    checkOutput("midreset z rdata0", rdata_z[31:0], 32'h0);
    rst = 1'b0;

    runClear("reclear", 1'b0);
    readAllZero("post-reclear");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
